// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants and types for the instruction encoder and the fetch-side length check.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] FNONE    = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } enc_state_t;

endpackage

// File: rtl/y86_inst_len.sv
// Combinational icode/ifun -> instruction length, register-byte flag and validity.
// Define ENC_FNCHK_EN to also reject ifun values that are illegal for the icode.
module y86_inst_len
   import y86_pkg::*;
(
   input  logic [3:0] i_icode,
   input  logic [3:0] i_ifun,
   output logic [3:0] o_len,
   output logic       o_has_reg,
   output logic       o_valid
);

`ifdef ENC_FNCHK_EN
   localparam logic FNCHK_EN = 1'b1;
`else
   localparam logic FNCHK_EN = 1'b0;
`endif

   logic w_icode_ok;
   logic w_fn_ok;

   always_comb begin
      o_len      = 4'd0;
      o_has_reg  = 1'b0;
      w_icode_ok = 1'b1;
      w_fn_ok    = (i_ifun == 4'h0);
      case (i_icode)
         I_HALT, I_NOP, I_RET: o_len = 4'd1;
         I_RRMOVQ: begin
            o_len     = 4'd2;
            o_has_reg = 1'b1;
            w_fn_ok   = (i_ifun <= 4'd6);
         end
         I_OPQ: begin
            o_len     = 4'd2;
            o_has_reg = 1'b1;
            w_fn_ok   = (i_ifun <= 4'd3);
         end
         I_PUSHQ, I_POPQ: begin
            o_len     = 4'd2;
            o_has_reg = 1'b1;
         end
         I_JXX: begin
            o_len   = 4'd9;
            w_fn_ok = (i_ifun <= 4'd6);
         end
         I_CALL: o_len = 4'd9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            o_len     = 4'd10;
            o_has_reg = 1'b1;
         end
         default: w_icode_ok = 1'b0;
      endcase
      o_valid = w_icode_ok & (w_fn_ok | ~FNCHK_EN);
   end

endmodule

// File: rtl/y86_inst_encoder.sv
// Serialises decoded Y86-64 instruction fields into imem, one little-endian byte per cycle.
// Define ENC_FNCHK_EN to reject instructions whose ifun is illegal for their icode.
module y86_inst_encoder
   import y86_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        icode,
   input  logic [3:0]        ifun,
   input  logic [3:0]        ra,
   input  logic [3:0]        rb,
   input  logic [63:0]       valc,
   output logic              mem_we,
   input  logic              mem_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] wr_ptr
);

   enc_state_t        r_state;
   enc_state_t        w_next_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [3:0]        r_idx;
   logic [3:0]        r_len;
   logic              r_has_reg;
   logic [3:0]        r_icode;
   logic [3:0]        r_ifun;
   logic [3:0]        r_ra;
   logic [3:0]        r_rb;
   logic [63:0]       r_valc;
   logic              r_done;
   logic              r_err;

   logic [3:0]        w_len;
   logic              w_has_reg;
   logic              w_valid;
   logic              w_hs;
   logic              w_accept;
   logic              w_last;
   logic [2:0]        w_vsel;
   logic [7:0]        w_byte;

   y86_inst_len u_len (
      .i_icode   (icode),
      .i_ifun    (ifun),
      .o_len     (w_len),
      .o_has_reg (w_has_reg),
      .o_valid   (w_valid)
   );

   assign w_hs     = (r_state == IDLE) & in_valid;
   assign w_accept = (r_state == EMIT) & ~mem_wait;
   assign w_last   = w_accept & (r_idx == 4'(r_len - 4'd1));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_hs && w_valid) w_next_state = EMIT;
         EMIT:    if (w_last)          w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // NOTE: the latched instruction fields are only read in EMIT, after a handshake has
   // loaded them, so they carry no reset and only the control state is cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_idx    <= 4'd0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= w_last;
         r_err  <= w_hs & ~w_valid;
         if (r_state == IDLE) begin
            if (addr_load) r_wr_ptr <= start_addr;
            if (w_hs) begin
               r_idx     <= 4'd0;
               r_len     <= w_len;
               r_has_reg <= w_has_reg;
               r_icode   <= icode;
               r_ifun    <= ifun;
               r_ra      <= ra;
               r_rb      <= rb;
               r_valc    <= valc;
            end
         end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_idx    <= r_idx + 4'd1;
         end
      end
   end

   // valC byte number: byte index minus the opcode byte and, if present, the register byte
   assign w_vsel = 3'(r_idx - (r_has_reg ? 4'd2 : 4'd1));

   always_comb begin
      w_byte = r_valc[{w_vsel, 3'b000} +: 8];
      if (r_idx == 4'd0)                 w_byte = {r_icode, r_ifun};
      else if (r_has_reg && r_idx == 4'd1) w_byte = {r_ra, r_rb};
   end

   assign in_ready  = (r_state == IDLE);
   assign mem_we    = (r_state == EMIT);
   assign mem_addr  = r_wr_ptr;
   assign mem_wdata = mem_we ? w_byte : 8'h00;
   assign done      = r_done;
   assign err       = r_err;
   assign wr_ptr    = r_wr_ptr;

endmodule

// File: tb/tb_y86_inst_encoder.sv
// Scoreboard bench for y86_inst_encoder: expected imem writes are queued at handshake and matched on acceptance.
module tb_y86_inst_encoder;

   localparam int ADDR_W = 64;

   logic              clk;
   logic              rst;
   logic              addr_load;
   logic [ADDR_W-1:0] start_addr;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        icode, ifun, ra, rb;
   logic [63:0]       valc;
   logic              mem_we;
   logic              mem_wait;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              done, err;
   logic [ADDR_W-1:0] wr_ptr;

   int n_checks = 0;
   int n_errors = 0;

   logic [71:0] sb_q[$];
   logic [63:0] model_ptr;

   y86_inst_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .addr_load(addr_load), .start_addr(start_addr),
      .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
      .ra(ra), .rb(rb), .valc(valc), .mem_we(mem_we), .mem_wait(mem_wait),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done), .err(err),
      .wr_ptr(wr_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_len(input logic [3:0] ic, input logic [3:0] fn);
      int len;
      case (ic)
         4'h0, 4'h1, 4'h9:       len = 1;
         4'h2, 4'h6, 4'hA, 4'hB: len = 2;
         4'h7, 4'h8:             len = 9;
         4'h3, 4'h4, 4'h5:       len = 10;
         default:                len = 0;
      endcase
`ifdef ENC_FNCHK_EN
      if (ic == 4'h6) begin
         if (fn > 4'd3) len = 0;
      end else if (ic == 4'h2 || ic == 4'h7) begin
         if (fn > 4'd6) len = 0;
      end else if (fn != 4'h0) begin
         len = 0;
      end
`endif
      return len;
   endfunction

   function automatic logic [7:0] model_byte(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [3:0] ra_i, input logic [3:0] rb_i,
                                             input logic [63:0] vc, input int idx);
      int  len;
      bit  hr;
      int  k;
      len = model_len(ic, fn);
      hr  = (len == 2) || (len == 10);
      if (idx == 0) return {ic, fn};
      if (hr && idx == 1) return {ra_i, rb_i};
      k = idx - (hr ? 2 : 1);
      return vc[k*8 +: 8];
   endfunction

   // Write monitor: every accepted byte must match the head of the scoreboard
   always @(negedge clk) begin
      logic [71:0] e;
      if (!rst && mem_we && !mem_wait) begin
         if (sb_q.size() == 0) begin
            check("spurious_we", {63'b0, mem_we}, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", mem_addr, e[71:8]);
            check("wr_data", {56'b0, mem_wdata}, {56'b0, e[7:0]});
         end
      end
   end

   // Sends one instruction; stalls stall_cyc cycles on byte number stall_byte (-1 = none)
   task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra_i,
                       input logic [3:0] rb_i, input logic [63:0] vc, input bit ld,
                       input logic [63:0] la, input int stall_byte, input int stall_cyc);
      int len, c, nacc, nst;
      bit hit;
      len = model_len(ic, fn);
      for (int w = 0; w < 20 && !in_ready; w++) begin
         @(posedge clk); #1;
      end
      check("in_ready_before", {63'b0, in_ready}, 64'd1);
      if (ld) model_ptr = la;
      for (int i = 0; i < len; i++)
         sb_q.push_back({model_ptr + 64'(i), model_byte(ic, fn, ra_i, rb_i, vc, i)});
      icode = ic; ifun = fn; ra = ra_i; rb = rb_i; valc = vc;
      addr_load = ld; start_addr = la; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; addr_load = 1'b0;
      icode = 4'($urandom); ifun = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
      valc = {$urandom, $urandom}; start_addr = {$urandom, $urandom};
      nacc = 0; nst = 0; hit = 1'b0;
      for (c = 1; c <= 60; c++) begin
         mem_wait = (nacc == stall_byte) && (nst < stall_cyc);
         if (mem_wait) nst++;
         @(negedge clk);
         if (mem_wait) begin
            check("hold_addr", mem_addr, model_ptr + 64'(nacc));
            check("hold_data", {56'b0, mem_wdata},
                  {56'b0, model_byte(ic, fn, ra_i, rb_i, vc, nacc)});
         end
         if (done || err) begin
            hit = 1'b1;
            break;
         end
         if (mem_we && !mem_wait) nacc++;
         @(posedge clk); #1;
      end
      mem_wait = 1'b0;
      check("finished", {63'b0, hit}, 64'd1);
      check("done", {63'b0, done}, {63'b0, len != 0});
      check("err", {63'b0, err}, {63'b0, len == 0});
      check("bytes", 64'(nacc), 64'(len));
      check("latency", 64'(c), (len == 0) ? 64'd1 : 64'(len + 1 + stall_cyc));
      check("in_ready_after", {63'b0, in_ready}, 64'd1);
      model_ptr = model_ptr + 64'(len);
      check("wr_ptr", wr_ptr, model_ptr);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; addr_load = 1'b0; start_addr = '0; in_valid = 1'b0;
      icode = 4'h0; ifun = 4'h0; ra = 4'hF; rb = 4'hF; valc = '0; mem_wait = 1'b0;
      model_ptr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check("rst_mem_we", {63'b0, mem_we}, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", {56'b0, mem_wdata}, 64'd0);
      check("rst_done_err", {62'b0, done, err}, 64'd0);
      check("rst_wr_ptr", wr_ptr, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // halt, irmovq, jmp
      send(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 1'b1, 64'h0, -1, 0);
      send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 1'b1, 64'h100, -1, 0);
      send(4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 1'b1, 64'h20, -1, 0);

      // invalid icode, then OPq with out-of-range ifun
      send(4'hC, 4'h0, 4'h1, 4'h2, 64'hDEAD, 1'b0, 64'h0, -1, 0);
      send(4'h6, 4'h7, 4'h2, 4'h3, 64'h0, 1'b0, 64'h0, -1, 0);

      // OPq with three stall cycles on byte1
      send(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 1'b1, 64'h200, 1, 3);

      // sweep every icode back to back from the running pointer
      for (int i = 0; i < 16; i++)
         send(4'(i), 4'h0, 4'($urandom), 4'($urandom), {$urandom, $urandom}, 1'b0, 64'h0, -1, 0);

      // irmovq stalled on its last valC byte
      send(4'h3, 4'h0, 4'hF, 4'h7, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 64'h400, 9, 2);

      // addr_load alone in IDLE
      addr_load = 1'b1; start_addr = 64'h5000;
      @(posedge clk); #1;
      addr_load = 1'b0;
      @(negedge clk);
      check("load_only_wr_ptr", wr_ptr, 64'h5000);
      check("load_only_no_we", {63'b0, mem_we}, 64'd0);
      model_ptr = 64'h5000;
      @(posedge clk); #1;

      // reset while byte4 of rmmovq is stalled
      model_ptr = 64'h300;
      for (int i = 0; i < 4; i++)
         sb_q.push_back({model_ptr + 64'(i), model_byte(4'h4, 4'h0, 4'h5, 4'h6, 64'h1122334455667788, i)});
      icode = 4'h4; ifun = 4'h0; ra = 4'h5; rb = 4'h6; valc = 64'h1122334455667788;
      addr_load = 1'b1; start_addr = 64'h300; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; addr_load = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      mem_wait = 1'b1; rst = 1'b1;
      @(negedge clk);
      check("pre_rst_addr", mem_addr, 64'h304);
      check("pre_rst_data", {56'b0, mem_wdata},
            {56'b0, model_byte(4'h4, 4'h0, 4'h5, 4'h6, 64'h1122334455667788, 4)});
      @(posedge clk); #1;
      rst = 1'b0; mem_wait = 1'b0;
      @(negedge clk);
      check("post_rst_we", {63'b0, mem_we}, 64'd0);
      check("post_rst_ready", {63'b0, in_ready}, 64'd1);
      check("post_rst_wr_ptr", wr_ptr, 64'd0);
      check("post_rst_done_err", {62'b0, done, err}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("post_rst_done2", {63'b0, done}, 64'd0);
      @(posedge clk); #1;
      model_ptr = '0;

      // pushq across the top of the address space
      send(4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
      check("wrap_wr_ptr", wr_ptr, 64'd1);

      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
